// File: rtl/acc_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the accumulator data unit.
// Optional reserved-opcode trap enabled by defining ILLEGAL_TRAP_EN.
module acc_control_unit #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned PC_WIDTH        = 8,
  parameter int unsigned OPERATION_WIDTH = 3,
  parameter int unsigned INSTR_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [INSTR_WIDTH-1:0]     instr,
  input  logic                       zero_flag,
  input  logic                       carrier_flag,
  input  logic                       negative_flag,
  output logic [PC_WIDTH-1:0]        pc,
  output logic                       instr_rd_en,
  output logic                       load_enable,
  output logic                       write_ram_enable,
  output logic [OPERATION_WIDTH-1:0] operation_select,
  output logic [1:0]                 a_select,
  output logic [1:0]                 b_select,
  output logic [1:0]                 destination_select,
  output logic [DATA_WIDTH-1:0]      constant_out,
  output logic                       mb_select,
  output logic                       md_select,
  output logic                       busy,
  output logic                       halted,
  output logic                       illegal_op
);

  localparam logic [3:0] OP_ALUR = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_BR   = 4'h5;
  localparam logic [3:0] OP_HALT = 4'h6;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [3:0] OP_RSVD = 4'h7;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_HALTED
  } state_t;

  state_t                 state;
  logic [INSTR_WIDTH-1:0] ir;
  logic                   flag_z;
  logic                   flag_c;
  logic                   flag_n;

  logic [3:0]             ir_op;
  logic [3:0]             in_op;
  logic [PC_WIDTH-1:0]    target;
  logic [PC_WIDTH-1:0]    pc_inc;
  logic [3:0]             cond_vec;
  logic                   br_taken;
  logic                   in_writes_reg;
  logic                   ir_is_alu;
  logic [PC_WIDTH-1:0]    exec_pc;
  logic                   exec_stop;
`ifdef ILLEGAL_TRAP_EN
  logic                   exec_trap;
`endif

  assign ir_op         = ir[15:12];
  assign in_op         = instr[15:12];
  assign target        = PC_WIDTH'(ir[7:0]);
  assign pc_inc        = pc + PC_WIDTH'(1);
  assign cond_vec      = {1'b1, flag_n, flag_c, flag_z};
  assign br_taken      = cond_vec[ir[11:10]];
  assign in_writes_reg = in_op[3] | (in_op == OP_ALUR) | (in_op == OP_LD);
  assign ir_is_alu     = ir_op[3] | (ir_op == OP_ALUR);

  // Outcome of the instruction held in ir when it executes.
  always_comb begin
    exec_pc   = pc_inc;
    exec_stop = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    exec_trap = 1'b0;
`endif
    case (ir_op)
      OP_JMP:  exec_pc = target;
      OP_BR:   exec_pc = br_taken ? target : pc_inc;
      OP_HALT: begin
        exec_pc   = pc;
        exec_stop = 1'b1;
      end
`ifdef ILLEGAL_TRAP_EN
      OP_RSVD: begin
        exec_pc   = pc;
        exec_stop = 1'b1;
        exec_trap = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Sequencer: state, pc, instruction register, latched flags and strobes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= S_IDLE;
      pc               <= '0;
      ir               <= '0;
      flag_z           <= 1'b0;
      flag_c           <= 1'b0;
      flag_n           <= 1'b0;
      instr_rd_en      <= 1'b0;
      load_enable      <= 1'b0;
      write_ram_enable <= 1'b0;
      busy             <= 1'b0;
      halted           <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_op       <= 1'b0;
`endif
    end else begin
      instr_rd_en      <= 1'b0;
      load_enable      <= 1'b0;
      write_ram_enable <= 1'b0;
      case (state)
        S_IDLE, S_HALTED: begin
          if (start) begin
            state       <= S_FETCH;
            pc          <= '0;
            flag_z      <= 1'b0;
            flag_c      <= 1'b0;
            flag_n      <= 1'b0;
            instr_rd_en <= 1'b1;
            busy        <= 1'b1;
            halted      <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_op  <= 1'b0;
`endif
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir               <= instr;
          load_enable      <= in_writes_reg;
          write_ram_enable <= (in_op == OP_ST);
          state            <= S_EXECUTE;
        end
        S_EXECUTE: begin
          pc <= exec_pc;
          if (ir_is_alu) begin
            flag_z <= zero_flag;
            flag_c <= carrier_flag;
            flag_n <= negative_flag;
          end
          if (exec_stop) begin
            state  <= S_HALTED;
            busy   <= 1'b0;
            halted <= 1'b1;
`ifdef ILLEGAL_TRAP_EN
            illegal_op <= exec_trap;
`endif
          end else begin
            state       <= S_FETCH;
            instr_rd_en <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifndef ILLEGAL_TRAP_EN
  assign illegal_op = 1'b0;
`endif

  // Data-unit selects decoded straight from the instruction register.
  always_comb begin
    operation_select   = '0;
    a_select           = 2'b00;
    b_select           = 2'b00;
    destination_select = 2'b00;
    constant_out       = '0;
    mb_select          = 1'b0;
    md_select          = 1'b0;
    if (state != S_IDLE) begin
      destination_select = ir[11:10];
      a_select           = ir[9:8];
      b_select           = ir[7:6];
      if (ir_op[3]) begin
        operation_select = OPERATION_WIDTH'(ir_op[2:0]);
        constant_out     = DATA_WIDTH'(ir[7:0]);
        mb_select        = 1'b1;
        b_select         = 2'b00;
      end else if (ir_op == OP_ALUR) begin
        operation_select = OPERATION_WIDTH'(ir[2:0]);
      end else if (ir_op == OP_LD) begin
        md_select = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_acc_control_unit.sv
// Bench for acc_control_unit: ISA-level reference model compared every cycle,
// plus directed programs with hand-computed expectations.
module tb_acc_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] instr = 16'h0000;
  logic        zero_flag;
  logic        carrier_flag;
  logic        negative_flag;
  logic [7:0]  pc;
  logic        instr_rd_en;
  logic        load_enable;
  logic        write_ram_enable;
  logic [2:0]  operation_select;
  logic [1:0]  a_select;
  logic [1:0]  b_select;
  logic [1:0]  destination_select;
  logic [7:0]  constant_out;
  logic        mb_select;
  logic        md_select;
  logic        busy;
  logic        halted;
  logic        illegal_op;

  int n_checks = 0;
  int n_fail   = 0;
  bit model_en = 1'b0;

  logic [15:0] rom [256];

  acc_control_unit dut (
    .clk(clk), .reset(reset), .start(start), .instr(instr),
    .zero_flag(zero_flag), .carrier_flag(carrier_flag), .negative_flag(negative_flag),
    .pc(pc), .instr_rd_en(instr_rd_en), .load_enable(load_enable),
    .write_ram_enable(write_ram_enable), .operation_select(operation_select),
    .a_select(a_select), .b_select(b_select), .destination_select(destination_select),
    .constant_out(constant_out), .mb_select(mb_select), .md_select(md_select),
    .busy(busy), .halted(halted), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  // Synchronous instruction ROM
  always @(posedge clk) if (instr_rd_en) instr <= rom[pc];

  logic [32:0] dut_vec;
  assign dut_vec = {pc, instr_rd_en, load_enable, write_ram_enable, operation_select,
                    a_select, b_select, destination_select, constant_out,
                    mb_select, md_select, busy, halted, illegal_op};

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  // ISA-level reference: phase 0/1/2 = fetch/decode/execute of one instruction.
  bit          m_active = 1'b0;
  bit          m_halt   = 1'b0;
  bit          m_ill    = 1'b0;
  int          m_phase  = 0;
  logic [7:0]  m_pc     = 8'h00;
  logic [15:0] m_ir     = 16'h0000;
  logic        m_z = 1'b0, m_c = 1'b0, m_n = 1'b0;

  function automatic bit stops(input logic [15:0] ir);
    return (ir[15:12] == 4'h6) || (TRAP && ir[15:12] == 4'h7);
  endfunction

  function automatic logic [7:0] next_pc(input logic [15:0] ir, input logic [7:0] p,
                                          input logic z, input logic c, input logic n);
    bit taken;
    case (ir[11:10])
      2'd0: taken = z;
      2'd1: taken = c;
      2'd2: taken = n;
      default: taken = 1'b1;
    endcase
    if (stops(ir)) return p;
    if (ir[15:12] == 4'h4) return ir[7:0];
    if (ir[15:12] == 4'h5 && taken) return ir[7:0];
    return p + 8'd1;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_active <= 1'b0; m_halt <= 1'b0; m_ill <= 1'b0; m_phase <= 0;
      m_pc <= 8'h00; m_ir <= 16'h0000; m_z <= 1'b0; m_c <= 1'b0; m_n <= 1'b0;
    end else if (!m_active || m_halt) begin
      if (start) begin
        m_active <= 1'b1; m_halt <= 1'b0; m_ill <= 1'b0; m_phase <= 0;
        m_pc <= 8'h00; m_z <= 1'b0; m_c <= 1'b0; m_n <= 1'b0;
      end
    end else if (m_phase == 0) begin
      m_phase <= 1;
    end else if (m_phase == 1) begin
      m_ir    <= rom[m_pc];
      m_phase <= 2;
    end else begin
      m_pc    <= next_pc(m_ir, m_pc, m_z, m_c, m_n);
      m_halt  <= stops(m_ir);
      m_ill   <= TRAP && (m_ir[15:12] == 4'h7);
      m_phase <= 0;
      if (m_ir[15] || m_ir[15:12] == 4'h1) begin
        m_z <= zero_flag; m_c <= carrier_flag; m_n <= negative_flag;
      end
    end
  end

  function automatic logic [32:0] expect_vec();
    logic [3:0] op;
    bit run, ex;
    logic [2:0] opsel;
    logic [1:0] a, b, d;
    logic [7:0] k;
    op  = m_ir[15:12];
    run = m_active && !m_halt;
    ex  = run && (m_phase == 2);
    opsel = 3'd0; a = 2'd0; b = 2'd0; d = 2'd0; k = 8'd0;
    if (m_active) begin
      d = m_ir[11:10];
      a = m_ir[9:8];
      b = op[3] ? 2'd0 : m_ir[7:6];
      k = op[3] ? m_ir[7:0] : 8'd0;
      opsel = op[3] ? op[2:0] : (op == 4'h1 ? m_ir[2:0] : 3'd0);
    end
    return {m_pc, run && (m_phase == 0),
            ex && (op[3] || op == 4'h1 || op == 4'h2), ex && (op == 4'h3),
            opsel, a, b, d, k,
            m_active && op[3], m_active && (op == 4'h2),
            run, m_halt, m_ill};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (model_en) check("model_cycle", 64'(dut_vec), 64'(expect_vec()));

  task automatic do_reset(input int n);
    reset = 1'b0;
    repeat (n) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input int budget, input bit rnd);
    for (int i = 0; i < budget && !halted; i++) begin
      @(negedge clk);
      if (rnd) begin
        {zero_flag, carrier_flag, negative_flag} = 3'($urandom);
        start = (i == 4);
      end
    end
    start = 1'b0;
    check("halt_reached", 64'(halted), 64'd1);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; start = 1'b0;
    zero_flag = 1'b0; carrier_flag = 1'b0; negative_flag = 1'b0;
    clear_rom();
    do_reset(2);
    model_en = 1'b1;
    check("reset_outputs", 64'(dut_vec), 64'd0);

    // ALUI then HALT
    rom[0] = 16'h8105; rom[1] = 16'h6000;
    pulse_start();
    check("fetch_pc0", 64'({instr_rd_en, pc}), 64'({1'b1, 8'h00}));
    repeat (2) @(negedge clk);
    check("alui_strobe", 64'({load_enable, mb_select, md_select, constant_out}),
          64'({1'b1, 1'b1, 1'b0, 8'h05}));
    wait_halt(20, 1'b0);
    check("halt_pc", 64'({halted, busy, pc}), 64'({1'b1, 1'b0, 8'h01}));
    pulse_start();
    check("restart", 64'({halted, busy, instr_rd_en, pc}), 64'({1'b0, 1'b1, 1'b1, 8'h00}));
    wait_halt(20, 1'b0);

    // Reset while entering EXECUTE of the ALUI
    pulse_start();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_reset", 64'(dut_vec), 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Conditional branches on latched flags
    clear_rom();
    rom[0] = 16'h8000; rom[1] = 16'h5010; rom[2] = 16'h6000; rom[8'h10] = 16'h6000;
    zero_flag = 1'b1;
    pulse_start(); wait_halt(30, 1'b0);
    check("br_z_taken", 64'(pc), 64'h10);
    zero_flag = 1'b0;
    pulse_start(); wait_halt(30, 1'b0);
    check("br_z_not_taken", 64'(pc), 64'h02);
    rom[1] = 16'h5410; carrier_flag = 1'b1;
    pulse_start(); wait_halt(30, 1'b0);
    check("br_c_taken", 64'(pc), 64'h10);
    carrier_flag = 1'b0;
    rom[0] = 16'h1005; rom[1] = 16'h5810; negative_flag = 1'b1;
    pulse_start();
    repeat (2) @(negedge clk);
    check("alur_strobe", 64'({load_enable, mb_select, operation_select}),
          64'({1'b1, 1'b0, 3'd5}));
    wait_halt(30, 1'b0);
    check("br_n_taken", 64'(pc), 64'h10);
    negative_flag = 1'b0;

    // Store then load
    clear_rom();
    rom[0] = 16'h3040; rom[1] = 16'h2400; rom[2] = 16'h6000;
    pulse_start();
    repeat (2) @(negedge clk);
    check("st_strobe", 64'({write_ram_enable, load_enable, a_select, b_select, mb_select}),
          64'({1'b1, 1'b0, 2'd0, 2'd1, 1'b0}));
    repeat (3) @(negedge clk);
    check("ld_strobe", 64'({load_enable, write_ram_enable, md_select, destination_select, a_select}),
          64'({1'b1, 1'b0, 1'b1, 2'd1, 2'd0}));
    wait_halt(20, 1'b0);
    check("stld_end_pc", 64'(pc), 64'h02);

    // Jump to 0xFF and wrap
    clear_rom();
    rom[0] = 16'h40FF; rom[8'hFF] = 16'h0000;
    pulse_start();
    repeat (3) @(negedge clk);
    check("jmp_target", 64'({instr_rd_en, pc}), 64'({1'b1, 8'hFF}));
    repeat (3) @(negedge clk);
    check("pc_wrap", 64'({instr_rd_en, pc}), 64'({1'b1, 8'h00}));
    do_reset(2);

    // Reserved opcode
    clear_rom();
    rom[0] = 16'h7000; rom[1] = 16'h6000;
    pulse_start(); wait_halt(20, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    check("illegal_trap", 64'({halted, illegal_op, pc}), 64'({1'b1, 1'b1, 8'h00}));
`else
    check("illegal_nop", 64'({halted, illegal_op, pc}), 64'({1'b1, 1'b0, 8'h01}));
`endif
    pulse_start();
    check("illegal_clear", 64'(illegal_op), 64'd0);
    wait_halt(20, 1'b0);

    // Random live flags; stray start while busy must be ignored
    clear_rom();
    rom[0] = 16'h8000; rom[1] = 16'h2400; rom[2] = 16'h5830; rom[3] = 16'h5C05;
    rom[5] = 16'h6000; rom[8'h30] = 16'h1005; rom[8'h31] = 16'h6000;
    for (int r = 0; r < 6; r++) begin
      pulse_start();
      wait_halt(60, 1'b1);
      check("rand_end_pc", 64'(pc == 8'h05 || pc == 8'h31), 64'd1);
    end

    model_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/acc_control_unit.md
Name: acc_control_unit

Overview:
- Multi-cycle sequencer for the accumulator-style data unit: register file, ALU, RAM and the constant/RAM muxes.
- Fetches 16-bit instructions from an external synchronous instruction ROM and decodes them into the data unit's control strobes.
- Latches ALU flags and resolves jumps and conditional branches.
- Sits between the instruction memory and the data unit in the single-cycle-processor top level.

Parameters:
- DATA_WIDTH, 8, width of the constant driven to the data unit
- PC_WIDTH, 8, program counter width (ROM depth 2^PC_WIDTH)
- OPERATION_WIDTH, 3, ALU operation select width
- INSTR_WIDTH, 16, instruction word width (fixed encoding below)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse, begin execution at pc=0
- instr  in  INSTR_WIDTH  ROM read data, valid the cycle after instr_rd_en
- zero_flag, carrier_flag, negative_flag  in  1 each  live ALU flags from the data unit
- pc  out  PC_WIDTH  ROM address
- instr_rd_en  out  1  ROM read strobe
- load_enable  out  1  register file write
- write_ram_enable  out  1  RAM write
- operation_select  out  OPERATION_WIDTH  ALU op
- a_select, b_select, destination_select  out  2 each  register indices
- constant_out  out  DATA_WIDTH  immediate to the data unit constant input
- mb_select  out  1  0 = reg_b, 1 = constant
- md_select  out  1  0 = ALU result, 1 = RAM data
- busy  out  1  in FETCH/DECODE/EXECUTE
- halted  out  1  HALT executed
- illegal_op  out  1  see Optional Feature

Behaviour:
- Reset (reset==0 at edge):
  - State IDLE; pc=0; instruction register=0; latched flags Z/C/N=0.
  - All outputs 0.
- FSM: IDLE -> FETCH (on start) -> DECODE -> EXECUTE -> FETCH ...
  - HALT opcode: EXECUTE -> HALTED.
  - HALTED -> FETCH on start, with pc=0 and flags cleared.
  - start is ignored in FETCH, DECODE and EXECUTE.
- FETCH: instr_rd_en=1 with pc driven.
- DECODE: capture instr into the instruction register.
- EXECUTE: load_enable and write_ram_enable pulse here only, for exactly one cycle. Enables are 0 in every other state.
- Selects and constant_out:
  - Driven combinationally from the instruction register in all states.
  - 0 in IDLE.
- Instruction latency: 3 cycles per instruction.
- Encoding: op = instr[15:12], d = [11:10], a = [9:8], b = [7:6], imm/target = [7:0].
- Opcodes:
  - 0x0 NOP: no strobes.
  - 0x1 ALUR: operation_select=instr[2:0], mb=0, md=0, load_enable=1.
  - 0x8-0xF ALUI: operation_select=op[2:0], constant_out=imm, mb=1, md=0, load_enable=1. b_select=0.
  - 0x2 LD: md=1, load_enable=1, destination=d, address reg=a.
  - 0x3 ST: write_ram_enable=1, mb=0, address reg=a, data reg=b.
  - 0x4 JMP: pc <= target[PC_WIDTH-1:0].
  - 0x5 BR: cond = instr[11:10], 00=Z, 01=C, 10=N, 11=always. If true, pc <= target; else pc+1.
  - 0x6 HALT: halted=1, busy=0, pc frozen.
  - 0x7: reserved.
- Flags:
  - Latched from the input flags at the end of EXECUTE of ALUR/ALUI only.
  - LD, ST and branches leave them unchanged.
  - BR uses the latched flags, never the live ones.
- PC:
  - pc+1 at the end of EXECUTE for non-jump ops.
  - Wraps modulo 2^PC_WIDTH (0xFF -> 0x00).
- Reset mid-instruction: abort immediately to IDLE. No strobe is asserted in that cycle.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: opcode 0x7 in EXECUTE -> HALTED with illegal_op=1 and no strobes. illegal_op is cleared by reset or start.
- Undefined: 0x7 executes as NOP and illegal_op is tied 0.

Test Plan:
- Reset low 2 cycles, then high -> all outputs 0, state IDLE. start -> pc=0, instr_rd_en=1 next cycle.
- ROM {0x8105 (ALUI add d=0 imm 5), 0x6000} -> single load_enable pulse in cycle 3 with constant_out=0x05, mb=1, then halted=1 at pc=1.
- ALUI producing zero_flag=1, then BR Z 0x5010 -> pc=0x10. Repeat with zero_flag=0 -> pc increments.
- ST 0x3040 then LD 0x2400 -> write_ram_enable pulse with a=0, b=1. Next instruction gives md=1, load_enable with d=1.
- JMP 0x40FF, NOP at 0xFF -> pc wraps to 0x00.
- Opcode 0x7000: with ILLEGAL_TRAP_EN, halted=1 and illegal_op=1. Without it, pc advances to 1 and illegal_op=0.
